// File: rtl/sw_conditioner.sv
// Switch input conditioner: 2-flop sync + per-bit debounce, SW[8] edge pulses,
// and a two-operand load FSM gated by the SW[9] run switch.
module sw_conditioner #(
  parameter int unsigned N        = 8,
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N+1:0] sw_raw,
  output logic [N+1:0] sw_out,
  output logic         sw8_rise,
  output logic         sw8_fall,
  output logic [N-1:0] x_val,
  output logic [N-1:0] y_val,
  output logic         xy_valid,
  output logic [1:0]   phase
);

  localparam int unsigned W = N + 2;
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    WaitX = 2'd0,
    WaitY = 2'd1,
    Done  = 2'd2
  } phase_e;

  logic [W-1:0]     r_s1, r_s2, r_st, w_st_d;
  logic [CNT_W-1:0] r_cnt   [W];
  logic [CNT_W-1:0] w_cnt_d [W];
  logic             r_rise, r_fall, r_valid;
  logic [N-1:0]     r_x, r_y;
  phase_e           r_phase;

  // A bit only flips after DEBOUNCE consecutive cycles disagreeing with the stable value.
  always_comb begin
    w_st_d = r_st;
    for (int i = 0; i < W; i++) begin
      w_cnt_d[i] = r_cnt[i] + CNT_W'(1);
      if (r_s2[i] == r_st[i]) begin
        w_cnt_d[i] = '0;
      end else if (r_cnt[i] == LastCnt) begin
        w_st_d[i]  = r_s2[i];
        w_cnt_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_st   <= '0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      for (int i = 0; i < W; i++) r_cnt[i] <= '0;
    end else begin
      r_s1   <= sw_raw;
      r_s2   <= r_s1;
      r_st   <= w_st_d;
      // Pulses land on the same edge as the new stable level.
      r_rise <= w_st_d[N] & ~r_st[N];
      r_fall <= ~w_st_d[N] & r_st[N];
      for (int i = 0; i < W; i++) r_cnt[i] <= w_cnt_d[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase <= WaitX;
      r_x     <= '0;
      r_y     <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (!r_st[N+1]) begin
        r_phase <= WaitX;
      end else begin
        case (r_phase)
          WaitX: if (r_rise) begin
            r_x     <= r_st[N-1:0];
            r_phase <= WaitY;
          end
          WaitY: if (r_rise) begin
            r_y     <= r_st[N-1:0];
            r_valid <= 1'b1;
            r_phase <= Done;
          end
          Done:    r_phase <= Done;
          default: r_phase <= WaitX;
        endcase
      end
    end
  end

  assign sw_out   = r_st;
  assign sw8_rise = r_rise;
  assign sw8_fall = r_fall;
  assign x_val    = r_x;
  assign y_val    = r_y;
  assign xy_valid = r_valid;
  assign phase    = r_phase;

endmodule

// File: tb/tb_sw_conditioner.sv
// Bench for sw_conditioner: window-based reference model checked every cycle,
// plus a vector table and directed sequences for load, DONE, priority and reset.
module tb_sw_conditioner;
  localparam int N  = 8;
  localparam int DB = 4;
  localparam int W  = N + 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] sw_raw;
  logic [W-1:0] sw_out;
  logic         sw8_rise, sw8_fall, xy_valid;
  logic [N-1:0] x_val, y_val;
  logic [1:0]   phase;

  sw_conditioner #(.N(N), .DEBOUNCE(DB), .CNT_W(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .sw_raw   (sw_raw),
    .sw_out   (sw_out),
    .sw8_rise (sw8_rise),
    .sw8_fall (sw8_fall),
    .x_val    (x_val),
    .y_val    (y_val),
    .xy_valid (xy_valid),
    .phase    (phase)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int n_rise, n_fall, n_valid;

  // Reference model state
  logic [W-1:0] q[$];
  int           k;
  int           last_flip [W];
  logic [W-1:0] m_st;
  logic         m_rise, m_fall, m_valid;
  logic [N-1:0] m_x, m_y;
  int           m_phase;

  typedef struct {
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic [N-1:0] exp_x;
    logic [N-1:0] exp_y;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    k = 0;
    for (int i = 0; i < W; i++) last_flip[i] = -1000;
    m_st = '0; m_rise = 0; m_fall = 0; m_valid = 0;
    m_x = '0; m_y = '0; m_phase = 0;
  endtask

  // One clock: advance the model at the rising edge, compare at the falling edge.
  task automatic tick();
    logic [W-1:0] old_st;
    logic         old_rise, all_mis, smp;
    int           idx;
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      k++;
      q.push_back(sw_raw);
      if (q.size() > DB + 3) void'(q.pop_front());
      old_st   = m_st;
      old_rise = m_rise;
      m_valid  = 1'b0;
      if (!old_st[N+1]) m_phase = 0;
      else if (m_phase == 0 && old_rise) begin m_x = old_st[N-1:0]; m_phase = 1; end
      else if (m_phase == 1 && old_rise) begin
        m_y = old_st[N-1:0]; m_valid = 1'b1; m_phase = 2;
      end
      // A bit flips once the last DB synchronised samples (all taken since the
      // previous flip) disagree with the stable value.
      for (int i = 0; i < W; i++) begin
        if (k - last_flip[i] >= DB) begin
          all_mis = 1'b1;
          for (int d = 0; d < DB; d++) begin
            idx = q.size() - 3 - d;
            smp = (idx >= 0) ? q[idx][i] : 1'b0;
            if (smp == old_st[i]) all_mis = 1'b0;
          end
          if (all_mis) begin
            m_st[i] = ~old_st[i];
            last_flip[i] = k;
          end
        end
      end
      m_rise = m_st[N] & ~old_st[N];
      m_fall = ~m_st[N] & old_st[N];
    end
    @(negedge clk);
    check("sw_out", 32'(sw_out), 32'(m_st));
    check("sw8_rise", 32'(sw8_rise), 32'(m_rise));
    check("sw8_fall", 32'(sw8_fall), 32'(m_fall));
    check("x_val", 32'(x_val), 32'(m_x));
    check("y_val", 32'(y_val), 32'(m_y));
    check("xy_valid", 32'(xy_valid), 32'(m_valid));
    check("phase", 32'(phase), 32'(m_phase));
    if (sw8_rise) n_rise++;
    if (sw8_fall) n_fall++;
    if (xy_valid) n_valid++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic load(input logic [N-1:0] x, input logic [N-1:0] y);
    sw_raw = {2'b10, x}; ticks(8);
    sw_raw = {2'b11, x}; ticks(8);
    sw_raw = {2'b10, x}; ticks(8);
    sw_raw = {2'b10, y}; ticks(8);
    sw_raw = {2'b11, y}; ticks(8);
  endtask

  task automatic restart();
    sw_raw = {2'b00, sw_raw[N-1:0]}; ticks(8);
    sw_raw = {2'b10, sw_raw[N-1:0]}; ticks(8);
  endtask

  vec_t vecs [4];

  initial begin
    logic [N-1:0] rx, ry;
    vecs[0] = '{x: 8'h7F, y: 8'h80, exp_x: 8'h7F, exp_y: 8'h80};
    vecs[1] = '{x: 8'h00, y: 8'hFF, exp_x: 8'h00, exp_y: 8'hFF};
    vecs[2] = '{x: 8'hA5, y: 8'h5A, exp_x: 8'hA5, exp_y: 8'h5A};
    vecs[3] = '{x: 8'h01, y: 8'h01, exp_x: 8'h01, exp_y: 8'h01};

    reset = 1'b1;
    sw_raw = '0;
    model_reset();
    ticks(2);
    reset = 1'b0;
    ticks(2);

    // Debounce filter: a 3-cycle pulse is swallowed, a held level lands on edge 6.
    sw_raw[0] = 1'b1; ticks(3);
    sw_raw[0] = 1'b0; ticks(10);
    check("glitch_dropped", 32'(sw_out[0]), 32'd0);
    sw_raw[0] = 1'b1; ticks(5);
    check("edge5_still_0", 32'(sw_out[0]), 32'd0);
    tick();
    check("edge6_is_1", 32'(sw_out[0]), 32'd1);

    // Operand load 05 / FB
    sw_raw = 10'h200; ticks(8);
    n_valid = 0;
    sw_raw = 10'h205; ticks(8);
    check("load_phase0", 32'(phase), 32'd0);
    sw_raw = 10'h305; ticks(8);
    check("load_phase1", 32'(phase), 32'd1);
    check("load_x", 32'(x_val), 32'h05);
    sw_raw = 10'h205; ticks(8);
    sw_raw = 10'h2FB; ticks(8);
    sw_raw = 10'h3FB; ticks(8);
    check("load_phase2", 32'(phase), 32'd2);
    check("load_x2", 32'(x_val), 32'h05);
    check("load_y", 32'(y_val), 32'hFB);
    check("load_valid_cnt", 32'(n_valid), 32'd1);

    // DONE ignores the strobe but edges still pulse
    sw_raw = 10'h27E; ticks(8);
    n_rise = 0; n_fall = 0;
    for (int i = 0; i < 3; i++) begin
      sw_raw = 10'h37E; ticks(8);
      sw_raw = 10'h27E; ticks(8);
    end
    check("done_rise_cnt", 32'(n_rise), 32'd3);
    check("done_fall_cnt", 32'(n_fall), 32'd3);
    check("done_x", 32'(x_val), 32'h05);
    check("done_y", 32'(y_val), 32'hFB);
    check("done_phase", 32'(phase), 32'd2);

    // Restart retains operands; run falling with a simultaneous strobe rise wins.
    sw_raw = 10'h07E; ticks(8);
    check("restart_phase", 32'(phase), 32'd0);
    check("restart_x", 32'(x_val), 32'h05);
    check("restart_y", 32'(y_val), 32'hFB);
    sw_raw = 10'h211; ticks(8);
    sw_raw = 10'h111; ticks(8);
    check("prio_phase", 32'(phase), 32'd0);
    check("prio_x", 32'(x_val), 32'h05);
    sw_raw = 10'h000; ticks(8);
    sw_raw = 10'h200; ticks(8);

    // Table-driven loads
    for (int v = 0; v < 4; v++) begin
      n_valid = 0;
      load(vecs[v].x, vecs[v].y);
      check("tbl_x", 32'(x_val), 32'(vecs[v].exp_x));
      check("tbl_y", 32'(y_val), 32'(vecs[v].exp_y));
      check("tbl_valid_cnt", 32'(n_valid), 32'd1);
      restart();
    end

    // Randomised loads
    for (int it = 0; it < 50; it++) begin
      rx = 8'($urandom % 127);
      ry = 8'($urandom % 127);
      load(rx, ry);
      check("rnd_x", 32'(x_val), 32'(rx));
      check("rnd_y", 32'(y_val), 32'(ry));
      restart();
    end

    // Asynchronous reset mid-operation, observed before the next clock edge
    sw_raw = 10'h3FF; ticks(8);
    #2;
    reset = 1'b1;
    #1;
    check("rst_sw_out", 32'(sw_out), 32'd0);
    check("rst_rise", 32'(sw8_rise), 32'd0);
    check("rst_fall", 32'(sw8_fall), 32'd0);
    check("rst_x", 32'(x_val), 32'd0);
    check("rst_y", 32'(y_val), 32'd0);
    check("rst_valid", 32'(xy_valid), 32'd0);
    check("rst_phase", 32'(phase), 32'd0);
    model_reset();
    ticks(2);
    reset = 1'b0;
    ticks(12);
    check("post_rst_sw_out", 32'(sw_out), 32'h3FF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sw_conditioner.md
# sw_conditioner

Input conditioner between the board switches and the picoMIPS `cpu` SW inputs. Each raw switch bit is synchronised and debounced, giving a clean `sw_out` bus that drives the cpu `SW` port directly. The block also detects SW[8] edges and runs a small load FSM that captures the two operands (x1, then y1) of the affine transform. The captured operands and the phase are exported for the self-checking bench and for LED/debug use.

## Interface
- `N`, default 8: operand width, which is the width of SW[N-1:0].
- `DEBOUNCE`, default 4: number of consecutive mismatching cycles before a stable bit changes. Legal range is 1 to 2^CNT_W−1.
- `CNT_W`, default 16: width of each debounce counter.

Ports:
- `clk` input 1: system clock. All state is updated on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `sw_raw` input N+2: asynchronous switch inputs. Bit N+1 is master run (SW[9]), bit N is load/show strobe (SW[8]), bits N-1:0 are data.
- `sw_out` output N+2: debounced, synchronous copy of `sw_raw`. Feeds cpu `SW`.
- `sw8_rise` output 1: one-cycle pulse on a 0→1 transition of `sw_out[N]`.
- `sw8_fall` output 1: one-cycle pulse on a 1→0 transition of `sw_out[N]`.
- `x_val` output N: captured operand x1, two's complement.
- `y_val` output N: captured operand y1, two's complement.
- `xy_valid` output 1: one-cycle pulse when y1 is captured.
- `phase` output 2: load FSM state. 0 = WAIT_X, 1 = WAIT_Y, 2 = DONE. The encoding 3 is never produced.

## Operation
- **Per bit i, synchroniser:** 2-flop chain `s1[i]` ← `sw_raw[i]`, `s2[i]` ← `s1[i]`.
- **Per bit i, debouncer:** the debouncer holds a stable bit `st[i]` and a counter `cnt[i]`.
  - If `s2[i]`==`st[i]`: `cnt[i]` ← 0.
  - Else if `cnt[i]`==DEBOUNCE−1: `st[i]` ← `s2[i]` and `cnt[i]` ← 0.
  - Else: `cnt[i]` ← `cnt[i]`+1.
  - Any glitch shorter than DEBOUNCE cycles at `s2` is discarded.
- **Output bus:** `sw_out` = `st`, taken directly from the registers.
- **Edge pulses:** `sw8_rise`/`sw8_fall` are registered. They are asserted at the same edge where `st[N]` updates, so each pulse coincides with the first cycle of the new `sw_out[N]` level.
- **Load FSM, priority order:**
  1. If `sw_out[N+1]`==0, the next state is WAIT_X. Captures and pulses are suppressed.
  2. WAIT_X on `sw8_rise`: `x_val` ← `sw_out[N-1:0]`, go to WAIT_Y.
  3. WAIT_Y on `sw8_rise`: `y_val` ← `sw_out[N-1:0]`, `xy_valid` ← 1 for one cycle, go to DONE.
  4. DONE: SW[8] edges are ignored; they select LED1/LED2 downstream. Stay in DONE until `sw_out[N+1]` goes to 0.
- **Capture value:** the captured value is `sw_out[N-1:0]` as registered in the cycle where `sw8_rise`=1. A data bit that changes in the same cycle as SW[8] is captured with its new value only if its debounce completed at or before that edge.
- **Operand retention:** `x_val`/`y_val` hold their values across returns to WAIT_X. They are overwritten only by a new capture.

## Timing
- **Reset values:** `s1`, `s2`, `st`, `cnt` = 0; `sw_out` = 0; `sw8_rise` = `sw8_fall` = `xy_valid` = 0; `x_val` = `y_val` = 0; `phase` = WAIT_X.
- **Reset mid-operation:** reset asserted during a debounce or load discards partial counts and state immediately; no clock is needed. After release, `sw_raw` is re-sampled from scratch.
- **Latency:** if `sw_raw[i]` changes and then holds, `sw_out[i]` changes on the (DEBOUNCE+2)th rising edge after the change. With default DEBOUNCE this is 6 edges.
- **Pulses:** `sw8_rise` is high the same cycle `sw_out[N]` first reads 1. `x_val` updates one edge later. `phase` advances on that same later edge.
- **`xy_valid`:** high for exactly one cycle, the cycle in which `y_val` first shows the new value.
- **Simultaneous events:** `sw_out[N+1]` falling in the same cycle as `sw8_rise` resolves to WAIT_X with no capture.
- **Counter range:** the counter never exceeds DEBOUNCE−1, so there is no wrap-around.

## Test plan
- **Reset:** assert `reset` mid-cycle with `sw_raw`=10'h3FF. All outputs read 0 and `phase`=0 asynchronously, before the next clock edge.
- **Debounce filter:** set `sw_raw[0]` 0→1 held for 3 cycles, then back to 0. `sw_out[0]` stays 0. Hold 1 for ≥4 cycles and `sw_out[0]`=1 on the 6th edge after the change.
- **Operand load:** `sw_raw[9]`=1, then data=8'h05 with SW[8] 0→1, then SW[8]→0, data=8'hFB, SW[8] 0→1.
  - Required: `x_val`=8'h05, `y_val`=8'hFB (−5).
  - One `xy_valid` pulse.
  - `phase` sequence 0→1→2.
- **DONE ignores strobe:** in DONE, toggle SW[8] three times with data=8'h7E. `x_val`/`y_val` unchanged. `sw8_rise`/`sw8_fall` still pulse once per edge.
- **Restart and priority:** drop SW[9] to 0. `phase`=0 after debounce; operands retained.
  - Drop SW[9] in the same cycle SW[8] rises, with SW[8] set 0→1 while `phase`=0 and data=8'h11. `phase` stays 0 and `x_val` is unchanged.
- **Randomised loop:** run 50 iterations of the load protocol with `$random % 127` operands, each followed by a SW[9] low→high restart. The captured `x_val`/`y_val` must match the applied values every iteration.
